poly_mult_seq: RTL and testbench

Host-side sequencer for the sparse polynomial multiplier core and its two operand memories: the position RAM (WEIGHT entries) and the random-bits RAM (Y words of RAMWIDTH bits).
- Accepts host commands over a valid/ready port and performs range-checked writes into both memories.
- Checks that every shift position has been loaded, then pulses the core's start and watches for completion with a watchdog.
- Reads back the X result words through the core's addr_result/rd_dout port and streams them to the host with backpressure.
- Sits between the CW305 register interface and poly_mult, and replaces ad-hoc load_i/key_i decoding.

---
 rtl/poly_mult_seq.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_poly_mult_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_mult_seq.sv
// Host-side sequencer for the sparse polynomial multiplier: loads the position and
// random-bits RAMs, launches the core under a watchdog and streams the result words out.
module poly_mult_seq #(
  parameter int WEIGHT     = 66,
  parameter int LOG_WEIGHT = 7,
  parameter int LOGW       = 16,
  parameter int RAMWIDTH   = 32,
  parameter int Y          = 553,
  parameter int X          = 1106,
  parameter int ADDR_WIDTH = 11,
  parameter int TIMEOUT    = 2000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [RAMWIDTH-1:0]   cmd_data,
  output logic                  pos_we,
  output logic [LOG_WEIGHT-1:0] pos_addr,
  output logic [LOGW-1:0]       pos_data,
  output logic                  rand_we,
  output logic [ADDR_WIDTH-1:0] rand_addr,
  output logic [RAMWIDTH-1:0]   rand_data,
  output logic                  core_rst,
  output logic                  core_start,
  input  logic                  core_valid,
  output logic [ADDR_WIDTH-1:0] core_addr_result,
  output logic                  core_rd_dout,
  input  logic [RAMWIDTH-1:0]   core_dout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [RAMWIDTH-1:0]   res_data,
  output logic                  res_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);

  localparam logic [1:0] OP_WR_POS  = 2'd0;
  localparam logic [1:0] OP_WR_RAND = 2'd1;
  localparam logic [1:0] OP_START   = 2'd2;
  localparam logic [1:0] OP_ABORT   = 2'd3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_CAP  = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [2:0]            state_q, state_d;
  logic [WEIGHT-1:0]     pos_loaded_q, pos_loaded_d;
  logic [1:0]            err_q, err_d;
  logic                  done_q, done_d;
  logic                  pos_we_q, pos_we_d;
  logic [LOG_WEIGHT-1:0] pos_addr_q, pos_addr_d;
  logic [LOGW-1:0]       pos_data_q, pos_data_d;
  logic                  rand_we_q, rand_we_d;
  logic [ADDR_WIDTH-1:0] rand_addr_q, rand_addr_d;
  logic [RAMWIDTH-1:0]   rand_data_q, rand_data_d;
  logic                  core_rst_q, core_rst_d;
  logic                  core_start_q, core_start_d;
  logic                  core_rd_q, core_rd_d;
  logic [ADDR_WIDTH-1:0] core_addr_q, core_addr_d;
  logic                  res_valid_q, res_valid_d;
  logic [RAMWIDTH-1:0]   res_data_q, res_data_d;
  logic                  res_last_q, res_last_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;

  logic idle_like;
  logic accept;
  logic pos_in_range;
  logic rand_in_range;
  logic last_word;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  // Gated by rst_n so every output, ready included, reads 0 while reset is held.
  assign cmd_ready = rst_n && (idle_like || (cmd_op == OP_ABORT));
  assign accept    = cmd_valid && cmd_ready;

  // Full-width compares: an out-of-range index must never alias into the RAM.
  assign pos_in_range  = 32'(cmd_addr) < 32'(WEIGHT);
  assign rand_in_range = 32'(cmd_addr) < 32'(Y);
  assign last_word     = rd_idx_q == ADDR_WIDTH'(X - 1);

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    pos_loaded_d = pos_loaded_q;
    err_d        = err_q;
    done_d       = done_q;
    pos_we_d     = 1'b0;
    pos_addr_d   = pos_addr_q;
    pos_data_d   = pos_data_q;
    rand_we_d    = 1'b0;
    rand_addr_d  = rand_addr_q;
    rand_data_d  = rand_data_q;
    core_rst_d   = 1'b0;
    core_start_d = 1'b0;
    core_rd_d    = 1'b0;
    core_addr_d  = core_addr_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_last_d   = res_last_q;
    rd_idx_d     = rd_idx_q;
    wdog_d       = wdog_q;

    if (accept && (cmd_op == OP_ABORT)) begin
      state_d      = S_IDLE;
      pos_loaded_d = '0;
      err_d        = 2'b00;
      done_d       = 1'b0;
      res_valid_d  = 1'b0;
      res_last_d   = 1'b0;
      core_rst_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            case (cmd_op)
              OP_WR_POS: begin
                if (pos_in_range) begin
                  pos_we_d   = 1'b1;
                  pos_addr_d = cmd_addr[LOG_WEIGHT-1:0];
                  pos_data_d = cmd_data[LOGW-1:0];
                  for (int i = 0; i < WEIGHT; i++) begin
                    if (32'(cmd_addr) == 32'(i)) pos_loaded_d[i] = 1'b1;
                  end
                end else begin
                  err_d[0] = 1'b1;
                end
              end
              OP_WR_RAND: begin
                if (rand_in_range) begin
                  rand_we_d   = 1'b1;
                  rand_addr_d = cmd_addr;
                  rand_data_d = cmd_data;
                end else begin
                  err_d[0] = 1'b1;
                end
              end
              OP_START: begin
                // From DONE a START only closes out the finished run.
                if (state_q == S_IDLE) begin
                  if (&pos_loaded_q) begin
                    err_d        = 2'b00;
                    state_d      = S_START;
                    core_start_d = 1'b1;
                  end else begin
                    err_d[0] = 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
        end

        S_START: begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end

        S_WAIT: begin
          if (core_valid) begin
            rd_idx_d    = '0;
            core_addr_d = '0;
            core_rd_d   = 1'b1;
            state_d     = S_RD_ADDR;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            wdog_d     = wdog_q + 1'b1;
            err_d[1]   = 1'b1;
            core_rst_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end

        S_RD_ADDR: state_d = S_RD_CAP;

        S_RD_CAP: begin
          res_data_d  = core_dout;
          res_valid_d = 1'b1;
          res_last_d  = last_word;
          state_d     = S_OUT;
        end

        S_OUT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            if (last_word) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              rd_idx_d    = rd_idx_q + 1'b1;
              core_addr_d = rd_idx_q + 1'b1;
              core_rd_d   = 1'b1;
              state_d     = S_RD_ADDR;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pos_loaded_q <= '0;
      err_q        <= 2'b00;
      done_q       <= 1'b0;
      pos_we_q     <= 1'b0;
      pos_addr_q   <= '0;
      pos_data_q   <= '0;
      rand_we_q    <= 1'b0;
      rand_addr_q  <= '0;
      rand_data_q  <= '0;
      core_rst_q   <= 1'b0;
      core_start_q <= 1'b0;
      core_rd_q    <= 1'b0;
      core_addr_q  <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_last_q   <= 1'b0;
      rd_idx_q     <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      pos_loaded_q <= pos_loaded_d;
      err_q        <= err_d;
      done_q       <= done_d;
      pos_we_q     <= pos_we_d;
      pos_addr_q   <= pos_addr_d;
      pos_data_q   <= pos_data_d;
      rand_we_q    <= rand_we_d;
      rand_addr_q  <= rand_addr_d;
      rand_data_q  <= rand_data_d;
      core_rst_q   <= core_rst_d;
      core_start_q <= core_start_d;
      core_rd_q    <= core_rd_d;
      core_addr_q  <= core_addr_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_last_q   <= res_last_d;
      rd_idx_q     <= rd_idx_d;
      wdog_q       <= wdog_d;
    end
  end

  assign pos_we           = pos_we_q;
  assign pos_addr         = pos_addr_q;
  assign pos_data         = pos_data_q;
  assign rand_we          = rand_we_q;
  assign rand_addr        = rand_addr_q;
  assign rand_data        = rand_data_q;
  assign core_rst         = core_rst_q;
  assign core_start       = core_start_q;
  assign core_rd_dout     = core_rd_q;
  assign core_addr_result = core_addr_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;
  assign res_last         = res_last_q;
  assign busy             = !idle_like;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_poly_mult_seq.sv
// Scoreboard bench for poly_mult_seq: a core model serves result words while a
// monitor compares RAM writes and the result stream against queued expectations.
module tb_poly_mult_seq;
  localparam int WEIGHT     = 66;
  localparam int LOG_WEIGHT = 7;
  localparam int LOGW       = 16;
  localparam int RAMWIDTH   = 32;
  localparam int Y          = 553;
  localparam int X          = 1106;
  localparam int ADDR_WIDTH = 11;
  localparam int TIMEOUT    = 150;
  localparam int CORE_DELAY = 100;

  localparam logic [1:0] OP_WR_POS  = 2'd0;
  localparam logic [1:0] OP_WR_RAND = 2'd1;
  localparam logic [1:0] OP_START   = 2'd2;
  localparam logic [1:0] OP_ABORT   = 2'd3;

  logic clk, rst_n;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [RAMWIDTH-1:0] cmd_data;
  logic pos_we;
  logic [LOG_WEIGHT-1:0] pos_addr;
  logic [LOGW-1:0] pos_data;
  logic rand_we;
  logic [ADDR_WIDTH-1:0] rand_addr;
  logic [RAMWIDTH-1:0] rand_data;
  logic core_rst, core_start, core_valid, core_rd_dout;
  logic [ADDR_WIDTH-1:0] core_addr_result;
  logic [RAMWIDTH-1:0] core_dout;
  logic res_valid, res_ready, res_last;
  logic [RAMWIDTH-1:0] res_data;
  logic busy, done;
  logic [1:0] err;

  poly_mult_seq #(
    .WEIGHT(WEIGHT), .LOG_WEIGHT(LOG_WEIGHT), .LOGW(LOGW), .RAMWIDTH(RAMWIDTH),
    .Y(Y), .X(X), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .pos_we(pos_we), .pos_addr(pos_addr), .pos_data(pos_data),
    .rand_we(rand_we), .rand_addr(rand_addr), .rand_data(rand_data),
    .core_rst(core_rst), .core_start(core_start), .core_valid(core_valid),
    .core_addr_result(core_addr_result), .core_rd_dout(core_rd_dout), .core_dout(core_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [LOG_WEIGHT+LOGW-1:0]     pos_q[$];
  logic [ADDR_WIDTH+RAMWIDTH-1:0] rand_q[$];
  logic [RAMWIDTH:0]              res_q[$];

  logic [RAMWIDTH-1:0] core_mem [X];
  bit core_respond = 1'b1;
  int core_cnt = 0;
  int ready_mode = 0;

  int pos_we_cnt = 0, core_start_cnt = 0, core_rst_cnt = 0;
  int res_count = 0, last_count = 0;
  int valid_cyc = 0, done_cyc = 0, start_cyc = 0, rst_cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  always @(posedge clk) cyc++;

  // Core model: result words appear one cycle after each read strobe.
  initial begin
    core_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || core_rst) begin
        core_valid = 1'b0;
        core_cnt = 0;
      end else if (core_start) begin
        core_valid = 1'b0;
        core_cnt = core_respond ? CORE_DELAY : 0;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_valid = 1'b1;
          valid_cyc = cyc;
        end
      end
    end
  end

  initial begin
    logic [ADDR_WIDTH-1:0] a;
    core_dout = '0;
    forever begin
      @(negedge clk);
      if (core_rd_dout) begin
        a = core_addr_result;
        @(posedge clk);
        #1 core_dout = core_mem[a];
      end
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: res_ready = 1'b1;
        2: res_ready = (cyc % 3 == 0);
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write or a result word.
  initial begin
    logic [RAMWIDTH:0] held;
    logic [RAMWIDTH:0] exp_w;
    bit stalled = 1'b0;
    bit done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (core_start) begin core_start_cnt++; start_cyc = cyc; end
        if (core_rst) begin core_rst_cnt++; rst_cyc = cyc; end
        if (pos_we) begin
          pos_we_cnt++;
          if (pos_q.size() == 0) fail("pos_we_unexpected");
          else check("pos_write", {pos_addr, pos_data}, pos_q.pop_front());
        end
        if (rand_we) begin
          if (rand_q.size() == 0) fail("rand_we_unexpected");
          else check("rand_write", {rand_addr, rand_data}, rand_q.pop_front());
        end
        if (res_valid && stalled) check("res_hold", {res_last, res_data}, held);
        if (res_valid && res_ready) begin
          res_count++;
          if (res_last) last_count++;
          if (res_q.size() == 0) fail("res_unexpected");
          else begin
            exp_w = res_q.pop_front();
            check("res_word", {res_last, res_data}, exp_w);
          end
          stalled = 1'b0;
        end else if (res_valid) begin
          stalled = 1'b1;
          held = {res_last, res_data};
        end else begin
          stalled = 1'b0;
        end
        if (done && !done_prev) done_cyc = cyc;
        done_prev = done;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input int addr, input logic [31:0] data);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = ADDR_WIDTH'(addr);
    cmd_data = data;
    #1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!cmd_ready) fail("cmd_accept");
    else @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = OP_WR_POS;
  endtask

  task automatic wr_pos(input int a, input logic [31:0] d);
    if (a < WEIGHT) pos_q.push_back({LOG_WEIGHT'(a), d[LOGW-1:0]});
    send_cmd(OP_WR_POS, a, d);
  endtask

  task automatic wr_rand(input int a, input logic [31:0] d);
    if (a < Y) rand_q.push_back({ADDR_WIDTH'(a), d});
    send_cmd(OP_WR_RAND, a, d);
  endtask

  task automatic load_results();
    for (int i = 0; i < X; i++) begin
      core_mem[i] = $urandom;
      res_q.push_back({(i == X - 1), core_mem[i]});
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin @(negedge clk); n++; end
    #1;
    if (!done) fail("done_timeout");
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctrl"}, {cmd_ready, pos_we, rand_we, core_rst, core_start, core_rd_dout,
                           res_valid, res_last, busy, done, err}, '0);
    check({tag, "_buses"}, {pos_addr, pos_data, rand_addr, rand_data, core_addr_result, res_data}, '0);
  endtask

  task automatic run_readout(input int mode, input int bound);
    int starts;
    res_count = 0;
    last_count = 0;
    ready_mode = mode;
    core_respond = 1'b1;
    starts = core_start_cnt;
    load_results();
    send_cmd(OP_START, 0, 0);
    check("start_clears_err", err, 2'b00);
    check("core_start_pulse", core_start, 1'b1);
    wait_done(bound);
    check("res_queue_empty", res_q.size(), 0);
    check("res_count", res_count, X);
    check("res_last_count", last_count, 1);
    check("busy_after_done", busy, 1'b0);
    check("one_core_start", core_start_cnt - starts, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int starts, rsts, n;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = OP_WR_POS;
    cmd_addr = '0;
    cmd_data = '0;
    wait_cycles(3);
    check_zero_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    #1 check("ready_after_reset", cmd_ready, 1'b1);

    // Positions 0..65, then out-of-range indices including one that would alias.
    for (int i = 0; i < WEIGHT; i++) wr_pos(i, {16'($urandom), 16'(16'h1000 + i)});
    wr_pos(WEIGHT, 32'h1042);
    wr_pos(128 + 5, 32'h1005);
    wait_cycles(3);
    check("pos_we_count", pos_we_cnt, WEIGHT);
    check("pos_queue_empty", pos_q.size(), 0);
    check("err_bad_pos", err, 2'b01);

    for (int i = 0; i < Y; i++) wr_rand(i, $urandom);
    wr_rand(Y, $urandom);
    wait_cycles(3);
    check("rand_queue_empty", rand_q.size(), 0);
    check("err_bad_rand", err, 2'b01);

    run_readout(1, 3 * X + CORE_DELAY + 50);
    check("valid_to_done_cycles", done_cyc - valid_cyc, 3 * X + 1);

    // Second run from DONE with backpressure: a write leaves DONE and clears done.
    wr_rand($urandom_range(Y - 1), $urandom);
    check("done_cleared_by_cmd", done, 1'b0);
    for (int i = 0; i < 8; i++) wr_rand($urandom_range(Y - 1), $urandom);
    run_readout(2, 6 * X + CORE_DELAY + 50);

    send_cmd(OP_ABORT, 0, 0);
    check("abort_idle_err", {busy, done, err}, 4'b0000);
    for (int i = 0; i < WEIGHT; i++) if (i != 17) wr_pos(i, $urandom);
    starts = core_start_cnt;
    send_cmd(OP_START, 0, 0);
    wait_cycles(5);
    check("missing_pos_err", err, 2'b01);
    check("missing_pos_no_start", core_start_cnt - starts, 0);
    check("missing_pos_idle", busy, 1'b0);

    // Reset while the core is running.
    wr_pos(17, $urandom);
    core_respond = 1'b0;
    send_cmd(OP_START, 0, 0);
    wait_cycles(20);
    check("busy_in_wait", busy, 1'b1);
    rst_n = 1'b0;
    #1 check_zero_outputs("reset_in_wait");
    @(negedge clk) rst_n = 1'b1;
    #1 check("ready_after_reset2", cmd_ready, 1'b1);
    starts = core_start_cnt;
    send_cmd(OP_START, 0, 0);
    wait_cycles(5);
    check("pos_cleared_by_reset", err, 2'b01);
    check("reset_no_start", core_start_cnt - starts, 0);

    // Watchdog expiry.
    for (int i = 0; i < WEIGHT; i++) wr_pos(i, $urandom);
    rsts = core_rst_cnt;
    send_cmd(OP_START, 0, 0);
    n = 0;
    while (core_rst_cnt == rsts && n < TIMEOUT + 50) begin @(negedge clk); n++; end
    wait_cycles(5);
    check("timeout_rst_pulses", core_rst_cnt - rsts, 1);
    check("timeout_latency", rst_cyc - start_cyc, TIMEOUT + 1);
    check("timeout_err", err, 2'b10);
    check("timeout_idle", busy, 1'b0);

    // ABORT while a word is stalled in OUT.
    ready_mode = 0;
    core_respond = 1'b1;
    load_results();
    send_cmd(OP_START, 0, 0);
    n = 0;
    while (!res_valid && n < CORE_DELAY + 20) begin @(negedge clk); n++; end
    if (!res_valid) fail("res_valid_wait");
    wait_cycles(4);
    send_cmd(OP_ABORT, 0, 0);
    check("abort_out_ctrl", {res_valid, busy, done, err, core_rst}, 6'b000001);
    res_q.delete();
    wait_cycles(2);
    send_cmd(OP_START, 0, 0);
    wait_cycles(3);
    check("abort_clears_pos", err, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
